dp_scrambler: RTL and testbench
===============================

Name: dp_scrambler

Overview:
- Lane-output stage directly downstream of the DisplayPort stuffing/framing stage.
- Takes the two 16-bit lanes (2 symbols per lane per dpclk, low byte first, per-byte K flags) and replaces every 512th BS with SR.
- Scrambles data symbols with the DP LFSR and registers the result for the 8b/10b encoder / transceiver.
- One shared LFSR serves both lanes, since the framing stage emits BS/SR on both lanes in the same cycle.

Parameters:
- SR_PERIOD, 512, number of BS occurrences per SR substitution; the SR replaces BS number SR_PERIOD (counting from 1).
- SEED, 16'hFFFF, LFSR value loaded on reset and after every BS/SR symbol.

Ports:
- dpclk  in  1  link symbol clock
- reset  in  1  reset; synchronous, active-low (0 = reset)
- dpdat0  in  16  lane 0 symbols; [7:0] first, [15:8] second
- dpdat1  in  16  lane 1 symbols, same layout
- dpisk0  in  2  lane 0 K flags; bit n qualifies byte n
- dpisk1  in  2  lane 1 K flags
- scren  in  1  1 = scramble data symbols, 0 = pass-through (SR substitution still active)
- scrdat0  out  16  lane 0 output symbols
- scrdat1  out  16  lane 1 output symbols
- scrisk0  out  2  lane 0 output K flags
- scrisk1  out  2  lane 1 output K flags

Behaviour:
- Reset (reset=0 at a dpclk edge):
  - scrdat0/1 <= 0 and scrisk0/1 <= 0.
  - lfsr <= SEED and bsctr <= 0.
- Latency: exactly 1 dpclk, input to output. There is no handshake; a valid symbol pair arrives every cycle.
- Symbol order per cycle: byte0 is processed first, then byte1. The LFSR advances 8 steps per symbol.
- Input symbols are evaluated on lane 0 only; lane 1 is assumed framed identically. Both lanes use the same keystream byte for a given symbol slot.
- LFSR: G(x) = x^16+x^5+x^4+x^3+1.
  - Keystream bit i of a byte = lfsr[15-i], taken before stepping.
  - Step: fb = lfsr[15]; lfsr = {lfsr[14:0],1'b0} ^ (fb ? 16'h0039 : 0).
- Per symbol slot, byte b in 0..1:
  - K flag with value `symBS`: bsctr increments; at wrap (bsctr == SR_PERIOD-1) the symbol becomes `symSR` with K kept and bsctr <= 0. In both cases the LFSR is reset to SEED for the next symbol.
  - Other K flag: output unchanged, not scrambled; LFSR advances.
  - Data symbol: output = data ^ keystream when scren=1, else data. The LFSR advances regardless of scren.
- Both bytes K28.5 in one cycle: counted in order; the seed reload after byte1 dominates.
- bsctr width is $clog2(SR_PERIOD). Wrap is modulo SR_PERIOD.

Optional Feature:
- Macro: DP_TRAINPAT_EN.
- When defined, the block adds input tps [1:0]:
  - 0: normal operation.
  - 1: TPS1, every symbol D10.2 (8'h4A), K=0, unscrambled.
  - 2: TPS2, the 10-symbol sequence K28.5, D11.6, K28.5, D11.6, then six D10.2. This is 5 cycles per period, driven by a 3-bit phase counter that restarts at 0 whenever tps changes.
  - 3: reserved, behaves as 1.
- While tps != 0:
  - LFSR held at SEED; bsctr held at 0.
  - Both lanes output the same pattern.
- Without the macro, the tps port, the phase counter and the pattern mux are absent.

Decomposition:
- dport.vh adds `symSR (8'h1C), `symD102 (8'h4A), `symD116 (8'hCB) and the LFSR seed/poly constants, next to the existing `symBS/`symBE/`symFS definitions.
- One natural sub-module: dp_lfsr_byte, combinational; inputs lfsr[15:0], outputs keystream[7:0] and next lfsr after 8 steps. It is instantiated twice in series, once per symbol slot.

Test Plan:
1. Reset low 2 cycles, then release; drive data 16'h0000, K=0, scren=1 on both lanes after a BS in the prior cycle → output bytes 8'hFF, 8'h17 then 8'hC0, 8'h14, identical on lanes 0 and 1.
2. Drive 511 BS symbols (BS in byte0 each cycle), then one more → the first 511 are emitted as 8'hBC with K=1; the 512th is emitted as 8'h1C with K=1; the 513th is 8'hBC again.
3. Set scren=0 with random data → output equals input delayed 1 cycle. Then set scren=1 without an intervening BS → the keystream continues from the advanced LFSR position, not from the seed.
4. Place a non-BS K symbol (`symBE) between data → K byte passes unscrambled and the LFSR still advances. Check against a reference model over 1000 random cycles.
5. Assert reset for 1 cycle mid-line → next output is 0; the next BS count restarts from 1 (SR on the 512th BS after reset).
6. (DP_TRAINPAT_EN) Drive tps=2 → repeating 5-cycle pattern {D11.6,K28.5}, {D11.6,K28.5}, {4A,4A} x3, with scrisk=2'b01 on the first two cycles. Then tps=0 → the first data symbol is scrambled with 8'hFF.

Source files
------------

// File: rtl/dp_scrambler_pkg.sv
// rtl/dp_scrambler_pkg.sv - DisplayPort symbol and LFSR constants shared by the lane-output stage
//
// Purpose: special symbol codes (K28.5 BS, SR, BE, FS, training data symbols),
//          LFSR seed/polynomial, training-pattern select encoding and the per-slot
//          output selection helper used by dp_scrambler.
package dp_scrambler_pkg;

  localparam logic [7:0]  SYM_BS    = 8'hBC;   // K28.5
  localparam logic [7:0]  SYM_SR    = 8'h1C;   // K28.0
  localparam logic [7:0]  SYM_BE    = 8'hFB;   // K27.7
  localparam logic [7:0]  SYM_FS    = 8'hFE;   // K30.7
  localparam logic [7:0]  SYM_D102  = 8'h4A;   // D10.2
  localparam logic [7:0]  SYM_D116  = 8'hCB;   // D11.6

  localparam logic [15:0] LFSR_SEED = 16'hFFFF;
  // x^16 + x^5 + x^4 + x^3 + 1, taps folded into the low bits after the shift
  localparam logic [15:0] LFSR_POLY = 16'h0039;

  typedef enum logic [1:0] {
    TPS_OFF  = 2'd0,
    TPS_1    = 2'd1,
    TPS_2    = 2'd2,
    TPS_RSVD = 2'd3
  } tps_e;

  localparam int TPS2_CYCLES = 5;

  // Output byte for one symbol slot. The K/data decision comes from lane 0,
  // so a lane 1 byte is treated the same way as its lane 0 counterpart.
  function automatic logic [7:0] slot_out(input logic [7:0] sym,
                                          input logic       is_k,
                                          input logic       sr_sub,
                                          input logic [7:0] ks,
                                          input logic       scr_on);
    logic [7:0] res;
    if (sr_sub) begin
      res = SYM_SR;
    end else if (is_k) begin
      res = sym;
    end else if (scr_on) begin
      res = sym ^ ks;
    end else begin
      res = sym;
    end
    return res;
  endfunction

endpackage

// File: rtl/dp_lfsr_byte.sv
// rtl/dp_lfsr_byte.sv - one symbol's worth (8 steps) of the DP scrambler LFSR
//
// Purpose: combinational; produces the keystream byte for the current LFSR
//          state and the state after 8 steps.
// Ports:
//   i_lfsr       in  16  current LFSR state
//   o_keystream  out  8  keystream byte, bit i = i_lfsr[15-i]
//   o_lfsr_next  out 16  LFSR state after 8 steps
module dp_lfsr_byte
  import dp_scrambler_pkg::*;
(
  input  logic [15:0] i_lfsr,
  output logic [7:0]  o_keystream,
  output logic [15:0] o_lfsr_next
);

  logic [15:0] w_lfsr;

  always_comb begin
    w_lfsr      = i_lfsr;
    o_keystream = '0;
    for (int i = 0; i < 8; i++) begin
      o_keystream[i] = i_lfsr[15-i];
      w_lfsr = {w_lfsr[14:0], 1'b0} ^ (w_lfsr[15] ? LFSR_POLY : 16'h0000);
    end
    o_lfsr_next = w_lfsr;
  end

endmodule

// File: rtl/dp_scrambler.sv
// rtl/dp_scrambler.sv - DisplayPort lane-output stage: SR substitution and data scrambling
//
// Purpose: takes two 16-bit lanes (two symbols per lane per dpclk, byte0 first),
//          replaces every SR_PERIOD-th BS with SR, scrambles data symbols with the
//          shared DP LFSR and registers the result (1 dpclk latency).
// Optional feature: macro DP_TRAINPAT_EN adds the tps input and a training
//          pattern generator (TPS1 / TPS2) that overrides both lanes.
// Ports:
//   dpclk           in   1  link symbol clock
//   reset           in   1  synchronous, active-low
//   dpdat0/dpdat1   in  16  lane symbols, [7:0] first, [15:8] second
//   dpisk0/dpisk1   in   2  K flags, bit n qualifies byte n
//   tps             in   2  training pattern select (DP_TRAINPAT_EN only)
//   scren           in   1  1 = scramble data symbols
//   scrdat0/scrdat1 out 16  registered output symbols
//   scrisk0/scrisk1 out  2  registered output K flags
module dp_scrambler
  import dp_scrambler_pkg::*;
#(
  parameter int          SR_PERIOD = 512,
  parameter logic [15:0] SEED      = LFSR_SEED
) (
  input  logic        dpclk,
  input  logic        reset,
  input  logic [15:0] dpdat0,
  input  logic [15:0] dpdat1,
  input  logic [1:0]  dpisk0,
  input  logic [1:0]  dpisk1,
`ifdef DP_TRAINPAT_EN
  input  logic [1:0]  tps,
`endif
  input  logic        scren,
  output logic [15:0] scrdat0,
  output logic [15:0] scrdat1,
  output logic [1:0]  scrisk0,
  output logic [1:0]  scrisk1
);

  localparam int                CTR_W    = $clog2(SR_PERIOD);
  localparam logic [CTR_W-1:0]  CTR_LAST = CTR_W'(SR_PERIOD - 1);

  logic [15:0]      r_lfsr;
  logic [CTR_W-1:0] r_bsctr;
  logic [15:0]      r_scrdat0;
  logic [15:0]      r_scrdat1;
  logic [1:0]       r_scrisk0;
  logic [1:0]       r_scrisk1;

  logic [7:0]       w_ks0;
  logic [7:0]       w_ks1;
  logic [15:0]      w_lfsr_n0;
  logic [15:0]      w_lfsr_n1;
  logic [15:0]      w_lfsr_in1;
  logic [15:0]      w_lfsr_next;
  logic             w_bs0;
  logic             w_bs1;
  logic             w_wrap0;
  logic             w_wrap1;
  logic [CTR_W-1:0] w_ctr_mid;
  logic [CTR_W-1:0] w_ctr_next;
  logic [15:0]      w_out0;
  logic [15:0]      w_out1;

  logic [15:0]      w_nxt_dat0;
  logic [15:0]      w_nxt_dat1;
  logic [1:0]       w_nxt_isk0;
  logic [1:0]       w_nxt_isk1;
  logic [15:0]      w_nxt_lfsr;
  logic [CTR_W-1:0] w_nxt_ctr;

  // Slot classification is taken from lane 0 only.
  assign w_bs0 = dpisk0[0] && (dpdat0[7:0]  == SYM_BS);
  assign w_bs1 = dpisk0[1] && (dpdat0[15:8] == SYM_BS);

  // BS counter is evaluated slot by slot so two BS in one cycle count in order.
  assign w_wrap0    = w_bs0 && (r_bsctr == CTR_LAST);
  assign w_ctr_mid  = w_bs0 ? (w_wrap0 ? '0 : r_bsctr + CTR_W'(1)) : r_bsctr;
  assign w_wrap1    = w_bs1 && (w_ctr_mid == CTR_LAST);
  assign w_ctr_next = w_bs1 ? (w_wrap1 ? '0 : w_ctr_mid + CTR_W'(1)) : w_ctr_mid;

  // Two byte stages in series; a BS/SR in a slot reseeds the stage after it.
  dp_lfsr_byte u_lfsr_b0 (
    .i_lfsr      (r_lfsr),
    .o_keystream (w_ks0),
    .o_lfsr_next (w_lfsr_n0)
  );

  assign w_lfsr_in1 = w_bs0 ? SEED : w_lfsr_n0;

  dp_lfsr_byte u_lfsr_b1 (
    .i_lfsr      (w_lfsr_in1),
    .o_keystream (w_ks1),
    .o_lfsr_next (w_lfsr_n1)
  );

  assign w_lfsr_next = w_bs1 ? SEED : w_lfsr_n1;

  assign w_out0 = {slot_out(dpdat0[15:8], dpisk0[1], w_wrap1, w_ks1, scren),
                   slot_out(dpdat0[7:0],  dpisk0[0], w_wrap0, w_ks0, scren)};
  assign w_out1 = {slot_out(dpdat1[15:8], dpisk0[1], w_wrap1, w_ks1, scren),
                   slot_out(dpdat1[7:0],  dpisk0[0], w_wrap0, w_ks0, scren)};

`ifdef DP_TRAINPAT_EN
  logic [1:0]  r_tps;
  logic [2:0]  r_phase;
  logic [2:0]  w_phase;
  logic        w_train;
  logic [15:0] w_pat;
  logic [1:0]  w_pat_k;

  // A change of tps restarts the TPS2 sequence in the same cycle.
  assign w_phase = (tps != r_tps) ? 3'd0 : r_phase;
  assign w_train = (tps != TPS_OFF);

  always_comb begin
    w_pat   = {SYM_D102, SYM_D102};
    w_pat_k = 2'b00;
    if ((tps == TPS_2) && (w_phase < 3'd2)) begin
      w_pat   = {SYM_D116, SYM_BS};
      w_pat_k = 2'b01;
    end
  end

  always_ff @(posedge dpclk) begin
    if (!reset) begin
      r_tps   <= 2'd0;
      r_phase <= 3'd0;
    end else begin
      r_tps   <= tps;
      r_phase <= (w_phase == 3'(TPS2_CYCLES - 1)) ? 3'd0 : w_phase + 3'd1;
    end
  end
`endif

  always_comb begin
    w_nxt_dat0 = w_out0;
    w_nxt_dat1 = w_out1;
    w_nxt_isk0 = dpisk0;
    w_nxt_isk1 = dpisk1;
    w_nxt_lfsr = w_lfsr_next;
    w_nxt_ctr  = w_ctr_next;
`ifdef DP_TRAINPAT_EN
    if (w_train) begin
      w_nxt_dat0 = w_pat;
      w_nxt_dat1 = w_pat;
      w_nxt_isk0 = w_pat_k;
      w_nxt_isk1 = w_pat_k;
      w_nxt_lfsr = SEED;
      w_nxt_ctr  = '0;
    end
`endif
  end

  always_ff @(posedge dpclk) begin
    if (!reset) begin
      r_lfsr    <= SEED;
      r_bsctr   <= '0;
      r_scrdat0 <= '0;
      r_scrdat1 <= '0;
      r_scrisk0 <= '0;
      r_scrisk1 <= '0;
    end else begin
      r_lfsr    <= w_nxt_lfsr;
      r_bsctr   <= w_nxt_ctr;
      r_scrdat0 <= w_nxt_dat0;
      r_scrdat1 <= w_nxt_dat1;
      r_scrisk0 <= w_nxt_isk0;
      r_scrisk1 <= w_nxt_isk1;
    end
  end

  assign scrdat0 = r_scrdat0;
  assign scrdat1 = r_scrdat1;
  assign scrisk0 = r_scrisk0;
  assign scrisk1 = r_scrisk1;

endmodule

// File: tb/tb_dp_scrambler.sv
// tb/tb_dp_scrambler.sv - self-checking bench for dp_scrambler (table vectors plus scoreboard)
module tb_dp_scrambler;

  localparam int          P_SR   = 512;
  localparam logic [15:0] P_SEED = 16'hFFFF;

  logic        dpclk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] dpdat0 = '0;
  logic [15:0] dpdat1 = '0;
  logic [1:0]  dpisk0 = '0;
  logic [1:0]  dpisk1 = '0;
  logic [1:0]  tps = 2'b00;
  logic        scren = 1'b0;
  logic [15:0] scrdat0;
  logic [15:0] scrdat1;
  logic [1:0]  scrisk0;
  logic [1:0]  scrisk1;

  always #5 dpclk = ~dpclk;

  dp_scrambler #(.SR_PERIOD(P_SR), .SEED(P_SEED)) dut (
    .dpclk   (dpclk),
    .reset   (reset),
    .dpdat0  (dpdat0),
    .dpdat1  (dpdat1),
    .dpisk0  (dpisk0),
    .dpisk1  (dpisk1),
`ifdef DP_TRAINPAT_EN
    .tps     (tps),
`endif
    .scren   (scren),
    .scrdat0 (scrdat0),
    .scrdat1 (scrdat1),
    .scrisk0 (scrisk0),
    .scrisk1 (scrisk1)
  );

  typedef struct packed {
    logic [15:0] d0;
    logic [15:0] d1;
    logic [1:0]  k0;
    logic [1:0]  k1;
  } out_t;

  typedef struct {
    logic [15:0] d0;
    logic [15:0] d1;
    logic [1:0]  k0;
    logic [1:0]  k1;
    logic        sc;
    out_t        exp;
  } vec_t;

  out_t        exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic        ovr_en = 1'b0;
  out_t        ovr_val = '0;

  logic [15:0] m_lfsr = P_SEED;
  int          m_ctr = 0;
  int          m_phase = 0;
  logic [1:0]  m_tps_prev = 2'b00;

  // Keystream collected from the MSB as the register shifts.
  task automatic gen_byte(input logic [15:0] l_in, output logic [7:0] ks, output logic [15:0] l_out);
    logic [15:0] l;
    l = l_in;
    for (int i = 0; i < 8; i++) begin
      ks[i] = l[15];
      if (l[15]) l = {l[14:0], 1'b0} ^ 16'h0039;
      else       l = {l[14:0], 1'b0};
    end
    l_out = l;
  endtask

  task automatic model_step(input logic rst_n, input logic [15:0] a0, input logic [15:0] a1,
                            input logic [1:0] k0, input logic [1:0] k1, input logic sc,
                            input logic [1:0] tp, output out_t e);
    logic [7:0]  s0, s1, o0, o1, ks;
    logic [15:0] nl;
    int          ph;
    e = '0;
    if (!rst_n) begin
      m_lfsr = P_SEED; m_ctr = 0; m_phase = 0; m_tps_prev = 2'b00;
    end else begin
      ph = (tp != m_tps_prev) ? 0 : m_phase;
      m_phase = (ph == 4) ? 0 : ph + 1;
      m_tps_prev = tp;
      if (tp != 2'b00) begin
        if (tp == 2'd2 && ph < 2) begin
          e.d0 = 16'hCBBC; e.d1 = 16'hCBBC; e.k0 = 2'b01; e.k1 = 2'b01;
        end else begin
          e.d0 = 16'h4A4A; e.d1 = 16'h4A4A; e.k0 = 2'b00; e.k1 = 2'b00;
        end
        m_lfsr = P_SEED; m_ctr = 0;
      end else begin
        e.k0 = k0; e.k1 = k1;
        for (int b = 0; b < 2; b++) begin
          s0 = a0[8*b +: 8];
          s1 = a1[8*b +: 8];
          if (k0[b] && s0 == 8'hBC) begin
            if (m_ctr == P_SR - 1) begin
              o0 = 8'h1C; o1 = 8'h1C; m_ctr = 0;
            end else begin
              o0 = s0; o1 = s1; m_ctr = m_ctr + 1;
            end
            m_lfsr = P_SEED;
          end else begin
            gen_byte(m_lfsr, ks, nl);
            m_lfsr = nl;
            if (k0[b] || !sc) begin
              o0 = s0; o1 = s1;
            end else begin
              o0 = s0 ^ ks; o1 = s1 ^ ks;
            end
          end
          e.d0[8*b +: 8] = o0;
          e.d1[8*b +: 8] = o1;
        end
      end
    end
  endtask

  task automatic check_out(input string name);
    out_t e, a;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL %s: scoreboard empty, got %h", name, {scrdat0, scrdat1, scrisk0, scrisk1});
    end else begin
      e = exp_q.pop_front();
      a = {scrdat0, scrdat1, scrisk0, scrisk1};
      if (a !== e) begin
        n_err++;
        $display("FAIL %s: got d0=%h d1=%h k0=%b k1=%b expected d0=%h d1=%h k0=%b k1=%b",
                 name, a.d0, a.d1, a.k0, a.k1, e.d0, e.d1, e.k0, e.k1);
      end
    end
  endtask

  task automatic check_const(input string name, input logic [17:0] act, input logic [17:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cycle(input logic rst_n, input logic [15:0] a0, input logic [15:0] a1,
                       input logic [1:0] k0, input logic [1:0] k1, input logic sc, input string name);
    out_t e;
    reset  = rst_n;
    dpdat0 = a0;
    dpdat1 = a1;
    dpisk0 = k0;
    dpisk1 = k1;
    scren  = sc;
    model_step(rst_n, a0, a1, k0, k1, sc, tps, e);
    exp_q.push_back(ovr_en ? ovr_val : e);
    @(posedge dpclk);
    #1;
    check_out(name);
  endtask

  vec_t tbl[5];

  initial begin
    logic [15:0] a0, a1;
    logic [1:0]  k;
    logic [7:0]  s;
    int          r;

    tbl[0] = '{d0:16'hBCBC, d1:16'hBCBC, k0:2'b11, k1:2'b11, sc:1'b1,
               exp:'{d0:16'hBCBC, d1:16'hBCBC, k0:2'b11, k1:2'b11}};
    tbl[1] = '{d0:16'h0000, d1:16'h0000, k0:2'b00, k1:2'b00, sc:1'b1,
               exp:'{d0:16'h17FF, d1:16'h17FF, k0:2'b00, k1:2'b00}};
    tbl[2] = '{d0:16'h0000, d1:16'hFFFF, k0:2'b00, k1:2'b00, sc:1'b1,
               exp:'{d0:16'h14C0, d1:16'hEB3F, k0:2'b00, k1:2'b00}};
    tbl[3] = '{d0:16'h1234, d1:16'h5678, k0:2'b00, k1:2'b00, sc:1'b0,
               exp:'{d0:16'h1234, d1:16'h5678, k0:2'b00, k1:2'b00}};
    tbl[4] = '{d0:16'hFB00, d1:16'hFB55, k0:2'b10, k1:2'b10, sc:1'b0,
               exp:'{d0:16'hFB00, d1:16'hFB55, k0:2'b10, k1:2'b10}};

    // reset state
    cycle(1'b0, 16'hA5A5, 16'h5A5A, 2'b11, 2'b11, 1'b1, "reset0");
    cycle(1'b0, 16'hA5A5, 16'h5A5A, 2'b11, 2'b11, 1'b1, "reset1");

    // first keystream bytes after a BS, both lanes
    for (int i = 0; i < 5; i++) begin
      ovr_en  = 1'b1;
      ovr_val = tbl[i].exp;
      cycle(1'b1, tbl[i].d0, tbl[i].d1, tbl[i].k0, tbl[i].k1, tbl[i].sc, $sformatf("table%0d", i));
      ovr_en  = 1'b0;
    end

    // SR on the 512th BS, counting from reset
    cycle(1'b0, 16'h0000, 16'h0000, 2'b00, 2'b00, 1'b1, "reset_sr");
    for (int n = 1; n <= 513; n++) begin
      cycle(1'b1, 16'h00BC, 16'h00BC, 2'b01, 2'b01, 1'b1, "bs_run");
      if (n == 1 || n == 511 || n == 512 || n == 513)
        check_const($sformatf("bs_n%0d", n), {scrisk0, scrdat0},
                    {2'b01, 8'hFF, (n == 512) ? 8'h1C : 8'hBC});
    end

    // pass-through, then scrambling resumes from the advanced LFSR
    for (int i = 0; i < 10; i++) begin
      a0 = 16'($urandom);
      a1 = 16'($urandom);
      cycle(1'b1, a0, a1, 2'b00, 2'b00, 1'b0, "passthru");
      check_const("passthru_lane0", {2'b00, scrdat0}, {2'b00, a0});
    end
    for (int i = 0; i < 5; i++)
      cycle(1'b1, 16'($urandom), 16'($urandom), 2'b00, 2'b00, 1'b1, "resume");

    // random mix of data, BE and BS symbols
    for (int i = 0; i < 1000; i++) begin
      a0 = 16'($urandom);
      a1 = 16'($urandom);
      k  = 2'b00;
      for (int b = 0; b < 2; b++) begin
        r = int'($urandom_range(0, 9));
        if (r < 2) begin
          s = (r == 0) ? 8'hBC : 8'hFB;
          a0[8*b +: 8] = s;
          a1[8*b +: 8] = s;
          k[b] = 1'b1;
        end
      end
      cycle(1'b1, a0, a1, k, k, ($urandom_range(0, 4) != 0), "random");
    end

    // reset mid-line restarts the BS count
    for (int i = 0; i < 100; i++)
      cycle(1'b1, 16'hBCBC, 16'hBCBC, 2'b11, 2'b11, 1'b1, "pre_reset");
    cycle(1'b0, 16'hBCBC, 16'hBCBC, 2'b11, 2'b11, 1'b1, "mid_reset");
    check_const("mid_reset_zero", {scrisk0, scrdat0}, 18'h0);
    for (int n = 1; n <= 512; n++) begin
      cycle(1'b1, 16'h00BC, 16'h00BC, 2'b01, 2'b01, 1'b1, "post_reset");
      if (n == 511 || n == 512)
        check_const($sformatf("post_reset_n%0d", n), {2'b00, scrdat0[7:0]},
                    {10'h0, (n == 512) ? 8'h1C : 8'hBC});
    end

    // wrap landing on byte1 of a double-BS cycle
    for (int i = 0; i < 255; i++)
      cycle(1'b1, 16'hBCBC, 16'hBCBC, 2'b11, 2'b11, 1'b1, "dbl_bs");
    cycle(1'b1, 16'hBCBC, 16'hBCBC, 2'b11, 2'b11, 1'b1, "dbl_bs_wrap");
    check_const("dbl_bs_wrap_lane1", {scrisk1, scrdat1}, {2'b11, 16'h1CBC});
    cycle(1'b1, 16'h0000, 16'h0000, 2'b00, 2'b00, 1'b1, "after_dbl");
    check_const("after_dbl_seed", {2'b00, scrdat0}, {2'b00, 16'h17FF});

`ifdef DP_TRAINPAT_EN
    tps = 2'd2;
    for (int i = 0; i < 12; i++) begin
      cycle(1'b1, 16'($urandom), 16'($urandom), 2'b00, 2'b00, 1'b1, "tps2");
      check_const($sformatf("tps2_p%0d", i % 5), {scrisk0, scrdat0},
                  ((i % 5) < 2) ? {2'b01, 16'hCBBC} : {2'b00, 16'h4A4A});
    end
    tps = 2'd1;
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 16'($urandom), 16'($urandom), 2'b00, 2'b00, 1'b1, "tps1");
    tps = 2'd3;
    cycle(1'b1, 16'($urandom), 16'($urandom), 2'b00, 2'b00, 1'b1, "tps3");
    tps = 2'd2;
    cycle(1'b1, 16'($urandom), 16'($urandom), 2'b00, 2'b00, 1'b1, "tps2_restart");
    check_const("tps2_restart_p0", {scrisk1, scrdat1}, {2'b01, 16'hCBBC});
    tps = 2'd0;
    cycle(1'b1, 16'h0000, 16'h0000, 2'b00, 2'b00, 1'b1, "tps_exit");
    check_const("tps_exit_seed", {2'b00, scrdat0}, {2'b00, 16'h17FF});
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
